// File: rtl/mfp_ahb_loader_arbiter.sv
// Hands the shared AHB fabric between the CPU master and the SREC loader byte stream.
// Loader bytes are queued, issued as single byte writes, and the stalled CPU gets its captured response replayed.
module mfp_ahb_loader_arbiter #(
    parameter int         FIFO_DEPTH   = 4,
    parameter logic [3:0] LOADER_HPROT = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic [31:0] CPU_HADDR,
    input  logic [31:0] CPU_HWDATA,
    input  logic [2:0]  CPU_HBURST,
    input  logic [2:0]  CPU_HSIZE,
    input  logic [3:0]  CPU_HPROT,
    input  logic [1:0]  CPU_HTRANS,
    input  logic        CPU_HWRITE,
    input  logic        CPU_HMASTLOCK,
    output logic [31:0] CPU_HRDATA,
    output logic        CPU_HREADY,
    output logic        CPU_HRESP,
    input  logic        in_progress,
    input  logic [31:0] write_address,
    input  logic [7:0]  write_byte,
    input  logic        write_enable,
    output logic [31:0] M_HADDR,
    output logic [31:0] M_HWDATA,
    output logic [2:0]  M_HBURST,
    output logic [2:0]  M_HSIZE,
    output logic [3:0]  M_HPROT,
    output logic [1:0]  M_HTRANS,
    output logic        M_HWRITE,
    output logic        M_HMASTLOCK,
    input  logic [31:0] S_HRDATA,
    input  logic        S_HREADY,
    input  logic        S_HRESP,
    output logic        grant_loader,
    output logic [4:0]  fifo_level,
    output logic        loader_overflow
);

    localparam int               PTR_W         = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE       = PTR_W'(1);
    localparam logic [PTR_W-1:0] PTR_ZERO      = PTR_W'(0);
    localparam logic [4:0]       LEVEL_FULL    = 5'(FIFO_DEPTH);
    localparam logic [1:0]       HTRANS_IDLE   = 2'b00;
    localparam logic [1:0]       HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0]       HSIZE_BYTE    = 3'b000;
    localparam logic [2:0]       HBURST_SINGLE = 3'b000;

    typedef enum logic [1:0] {
        ST_CPU    = 2'd0,
        ST_LOAD   = 2'd1,
        ST_REPLAY = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [39:0]      fifo_mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [4:0]       count_r;
    logic             overflow_r;
    logic             owner_r;
    logic [7:0]       data_r;
    logic [31:0]      replay_rdata_r;
    logic             replay_resp_r;

    logic             empty_s;
    logic             full_s;
    logic             load_req_s;
    logic             pop_s;
    logic             push_s;
    logic             drop_s;
    logic             switch_s;
    logic [39:0]      head_s;

    // FIFO status and the handshake decisions shared by the state machine and storage
    always_comb begin
        empty_s    = (count_r == 5'd0);
        full_s     = (count_r == LEVEL_FULL);
        head_s     = fifo_mem_r[rd_ptr_r];
        load_req_s = in_progress | ~empty_s;
        pop_s      = (state_r == ST_LOAD) & ~empty_s & S_HREADY;
        // a full FIFO still accepts when the head leaves in the same cycle
        push_s     = write_enable & (~full_s | pop_s);
        drop_s     = write_enable & full_s & ~pop_s;
        // the handover is held off while reset is asserted so outputs stay pure passthrough
        switch_s   = (state_r == ST_CPU) & load_req_s & S_HREADY & HRESETn;
    end

    // Next state and bus steering; defaults are the plain CPU passthrough
    always_comb begin
        state_s      = state_r;
        M_HADDR      = CPU_HADDR;
        M_HWDATA     = owner_r ? {4{data_r}} : CPU_HWDATA;
        M_HBURST     = CPU_HBURST;
        M_HSIZE      = CPU_HSIZE;
        M_HPROT      = CPU_HPROT;
        M_HTRANS     = CPU_HTRANS;
        M_HWRITE     = CPU_HWRITE;
        M_HMASTLOCK  = CPU_HMASTLOCK;
        CPU_HRDATA   = S_HRDATA;
        CPU_HREADY   = S_HREADY;
        CPU_HRESP    = S_HRESP;
        grant_loader = 1'b0;
        case (state_r)
            ST_CPU: begin
                if (switch_s) begin
                    M_HTRANS   = HTRANS_IDLE;
                    CPU_HREADY = 1'b0;
                    CPU_HRESP  = 1'b0;
                    state_s    = ST_LOAD;
                end else begin
                    state_s    = ST_CPU;
                end
            end
            ST_LOAD: begin
                grant_loader = 1'b1;
                CPU_HREADY   = 1'b0;
                CPU_HRESP    = 1'b0;
                M_HADDR      = head_s[39:8];
                M_HBURST     = HBURST_SINGLE;
                M_HSIZE      = HSIZE_BYTE;
                M_HPROT      = LOADER_HPROT;
                M_HWRITE     = 1'b1;
                M_HMASTLOCK  = 1'b0;
                if (empty_s) begin
                    M_HTRANS = HTRANS_IDLE;
                end else begin
                    M_HTRANS = HTRANS_NONSEQ;
                end
                if (!in_progress && empty_s && S_HREADY) begin
                    state_s = ST_REPLAY;
                end else begin
                    state_s = ST_LOAD;
                end
            end
            ST_REPLAY: begin
                CPU_HREADY = 1'b1;
                CPU_HRDATA = replay_rdata_r;
                CPU_HRESP  = replay_resp_r;
                state_s    = ST_CPU;
            end
            default: begin
                state_s = ST_CPU;
            end
        endcase
    end

    // FIFO storage, one {address, byte} record per entry
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem_r[i] <= 40'h00_0000_0000;
            end
        end else if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {write_address, write_byte};
        end
    end

    // FIFO pointers, occupancy and the sticky drop flag
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_ptr_r   <= PTR_ZERO;
            rd_ptr_r   <= PTR_ZERO;
            count_r    <= 5'd0;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 5'd1;
                2'b01:   count_r <= count_r - 5'd1;
                default: count_r <= count_r;
            endcase
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Ownership state, data-phase owner, loader write data and the CPU response held for replay
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r        <= ST_CPU;
            owner_r        <= 1'b0;
            data_r         <= 8'h00;
            replay_rdata_r <= 32'h0000_0000;
            replay_resp_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            if (S_HREADY) begin
                owner_r <= (state_r == ST_LOAD);
            end
            if (pop_s) begin
                data_r <= head_s[7:0];
            end
            if (switch_s) begin
                replay_rdata_r <= S_HRDATA;
                replay_resp_r  <= S_HRESP;
            end
        end
    end

    assign fifo_level      = count_r;
    assign loader_overflow = overflow_r;

endmodule

// File: tb/tb_mfp_ahb_loader_arbiter.sv
// Bench for mfp_ahb_loader_arbiter: directed vector table, corner-case sequences and a random run
// against a transaction-level model of the CPU, the loader queue and a wait-stating fabric.
module tb_mfp_ahb_loader_arbiter;

    localparam int DEPTH = 4;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic [31:0] CPU_HADDR, CPU_HWDATA, CPU_HRDATA;
    logic [2:0]  CPU_HBURST, CPU_HSIZE;
    logic [3:0]  CPU_HPROT;
    logic [1:0]  CPU_HTRANS;
    logic        CPU_HWRITE, CPU_HMASTLOCK, CPU_HREADY, CPU_HRESP;
    logic        in_progress, write_enable;
    logic [31:0] write_address;
    logic [7:0]  write_byte;
    logic [31:0] M_HADDR, M_HWDATA;
    logic [2:0]  M_HBURST, M_HSIZE;
    logic [3:0]  M_HPROT;
    logic [1:0]  M_HTRANS;
    logic        M_HWRITE, M_HMASTLOCK;
    logic [31:0] S_HRDATA;
    logic        S_HREADY, S_HRESP;
    logic        grant_loader, loader_overflow;
    logic [4:0]  fifo_level;

    always #5 HCLK = ~HCLK;

    mfp_ahb_loader_arbiter #(.FIFO_DEPTH(DEPTH), .LOADER_HPROT(4'b0011)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .CPU_HADDR(CPU_HADDR), .CPU_HWDATA(CPU_HWDATA), .CPU_HBURST(CPU_HBURST),
        .CPU_HSIZE(CPU_HSIZE), .CPU_HPROT(CPU_HPROT), .CPU_HTRANS(CPU_HTRANS),
        .CPU_HWRITE(CPU_HWRITE), .CPU_HMASTLOCK(CPU_HMASTLOCK),
        .CPU_HRDATA(CPU_HRDATA), .CPU_HREADY(CPU_HREADY), .CPU_HRESP(CPU_HRESP),
        .in_progress(in_progress), .write_address(write_address),
        .write_byte(write_byte), .write_enable(write_enable),
        .M_HADDR(M_HADDR), .M_HWDATA(M_HWDATA), .M_HBURST(M_HBURST), .M_HSIZE(M_HSIZE),
        .M_HPROT(M_HPROT), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE), .M_HMASTLOCK(M_HMASTLOCK),
        .S_HRDATA(S_HRDATA), .S_HREADY(S_HREADY), .S_HRESP(S_HRESP),
        .grant_loader(grant_loader), .fifo_level(fifo_level), .loader_overflow(loader_overflow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic ip, input logic we, input logic [31:0] wa, input logic [7:0] wb,
                         input logic shr, input logic [31:0] srd);
        in_progress   = ip;
        write_enable  = we;
        write_address = wa;
        write_byte    = wb;
        S_HREADY      = shr;
        S_HRDATA      = srd;
    endtask

    function automatic logic [31:0] rd_pattern(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3C3_3C3C;
    endfunction

    typedef struct {
        logic        ip;
        logic        we;
        logic [31:0] waddr;
        logic [7:0]  wbyte;
        logic        shr;
        logic [31:0] srdata;
        logic [31:0] cpu_addr;
        logic [1:0]  exp_htrans;
        logic        exp_hwrite;
        logic        chk_addr;
        logic [31:0] exp_haddr;
        logic [31:0] exp_hwdata;
        logic        exp_cpu_rdy;
        logic [31:0] exp_cpu_rdata;
        logic        exp_grant;
        logic [4:0]  exp_level;
    } vec_t;

    vec_t vecs [9];

    logic [39:0] q [$];
    logic [31:0] cpu_addr, cpu_prev, fab_cpu_next, dp_addr, start_addr;
    logic        cpu_has_prev, dp_active, dp_write, exp_ovf, ip;
    logic [7:0]  dp_byte, b;
    int          nwrites;
    logic        done;

    initial begin
        // CPU read traffic followed by a two-byte load and the replay of the stalled read
        vecs[0] = '{1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0,         32'h1FC0_0000, 2'b10, 1'b0, 1'b1, 32'h1FC0_0000, 32'h0BAD_F00D, 1'b1, 32'h0,         1'b0, 5'd0};
        vecs[1] = '{1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'hDEAD_BEEF, 32'h1FC0_0004, 2'b10, 1'b0, 1'b1, 32'h1FC0_0004, 32'h0BAD_F00D, 1'b1, 32'hDEAD_BEEF, 1'b0, 5'd0};
        vecs[2] = '{1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 32'h1234_5678, 32'h1FC0_0008, 2'b00, 1'b0, 1'b1, 32'h1FC0_0008, 32'h0BAD_F00D, 1'b0, 32'h0,         1'b0, 5'd0};
        vecs[3] = '{1'b1, 1'b1, 32'h1, 8'hA5, 1'b1, 32'h0,         32'h1FC0_0008, 2'b00, 1'b1, 1'b0, 32'h0,         32'h0BAD_F00D, 1'b0, 32'h0,         1'b1, 5'd0};
        vecs[4] = '{1'b1, 1'b1, 32'h2, 8'h3C, 1'b1, 32'h0,         32'h1FC0_0008, 2'b10, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0000, 1'b0, 32'h0,         1'b1, 5'd1};
        vecs[5] = '{1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0,         32'h1FC0_0008, 2'b10, 1'b1, 1'b1, 32'h0000_0002, 32'hA5A5_A5A5, 1'b0, 32'h0,         1'b1, 5'd1};
        vecs[6] = '{1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0,         32'h1FC0_0008, 2'b00, 1'b1, 1'b0, 32'h0,         32'h3C3C_3C3C, 1'b0, 32'h0,         1'b1, 5'd0};
        vecs[7] = '{1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0,         32'h1FC0_0008, 2'b10, 1'b0, 1'b1, 32'h1FC0_0008, 32'h3C3C_3C3C, 1'b1, 32'h1234_5678, 1'b0, 5'd0};
        vecs[8] = '{1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0000_AAAA, 32'h1FC0_000C, 2'b10, 1'b0, 1'b1, 32'h1FC0_000C, 32'h0BAD_F00D, 1'b1, 32'h0000_AAAA, 1'b0, 5'd0};

        HRESETn       = 1'b0;
        CPU_HADDR     = 32'h1FC0_0000;
        CPU_HWDATA    = 32'h0BAD_F00D;
        CPU_HBURST    = 3'b001;
        CPU_HSIZE     = 3'b010;
        CPU_HPROT     = 4'b0001;
        CPU_HTRANS    = 2'b10;
        CPU_HWRITE    = 1'b0;
        CPU_HMASTLOCK = 1'b0;
        S_HRESP       = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0);
        repeat (2) @(posedge HCLK);
        #1;
        check("rst_grant", 32'(grant_loader), 32'h0);
        check("rst_level", 32'(fifo_level), 32'h0);
        check("rst_ovf", 32'(loader_overflow), 32'h0);
        check("rst_htrans", 32'(M_HTRANS), 32'(CPU_HTRANS));
        HRESETn = 1'b1;

        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].ip, vecs[i].we, vecs[i].waddr, vecs[i].wbyte, vecs[i].shr, vecs[i].srdata);
            CPU_HADDR = vecs[i].cpu_addr;
            @(negedge HCLK);
            check($sformatf("vec%0d_htrans", i), 32'(M_HTRANS), 32'(vecs[i].exp_htrans));
            check($sformatf("vec%0d_hwrite", i), 32'(M_HWRITE), 32'(vecs[i].exp_hwrite));
            if (vecs[i].chk_addr) check($sformatf("vec%0d_haddr", i), M_HADDR, vecs[i].exp_haddr);
            check($sformatf("vec%0d_hwdata", i), M_HWDATA, vecs[i].exp_hwdata);
            check($sformatf("vec%0d_cpu_hready", i), 32'(CPU_HREADY), 32'(vecs[i].exp_cpu_rdy));
            if (vecs[i].exp_cpu_rdy) check($sformatf("vec%0d_cpu_hrdata", i), CPU_HRDATA, vecs[i].exp_cpu_rdata);
            check($sformatf("vec%0d_grant", i), 32'(grant_loader), 32'(vecs[i].exp_grant));
            check($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(vecs[i].exp_level));
            if (vecs[i].we) check($sformatf("vec%0d_hsize", i), 32'(M_HSIZE), 32'(vecs[i].exp_hwrite ? 3'b000 : 3'b010));
            step();
        end

        // Six bytes into a stalled fabric: four kept, two dropped, kept ones drained in order
        CPU_HADDR = 32'h1FC0_0010;
        drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0000_BBBB);
        @(negedge HCLK);
        check("ovf_switch_htrans", 32'(M_HTRANS), 32'h0);
        check("ovf_switch_hready", 32'(CPU_HREADY), 32'h0);
        step();
        for (int i = 0; i < 10; i++) begin
            b = 8'hB0 + 8'(i);
            drive(1'b1, (i < 6), 32'h100 + 32'(i), b, 1'b0, 32'h0);
            step();
        end
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0);
        @(negedge HCLK);
        check("ovf_level", 32'(fifo_level), 32'd4);
        check("ovf_flag", 32'(loader_overflow), 32'h1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge HCLK);
            check($sformatf("ovf_w%0d_htrans", k), 32'(M_HTRANS), 32'h2);
            check($sformatf("ovf_w%0d_haddr", k), M_HADDR, 32'h100 + 32'(k));
            b = 8'hB0 + 8'(k) - 8'd1;
            if (k > 0) check($sformatf("ovf_w%0d_hwdata", k), M_HWDATA, {4{b}});
            step();
        end
        @(negedge HCLK);
        check("ovf_tail_htrans", 32'(M_HTRANS), 32'h0);
        check("ovf_tail_hwdata", M_HWDATA, 32'hB3B3_B3B3);
        check("ovf_tail_hready", 32'(CPU_HREADY), 32'h0);
        step();
        @(negedge HCLK);
        check("ovf_replay_hready", 32'(CPU_HREADY), 32'h1);
        check("ovf_replay_rdata", CPU_HRDATA, 32'h0000_BBBB);
        check("ovf_replay_haddr", M_HADDR, 32'h1FC0_0010);
        check("ovf_replay_grant", 32'(grant_loader), 32'h0);
        step();

        // in_progress drops with three bytes queued; CPU stays stalled until they are all written
        CPU_HADDR = 32'h1FC0_0014;
        drive(1'b1, 1'b1, 32'h200, 8'h11, 1'b1, 32'h0);
        step();
        drive(1'b1, 1'b1, 32'h201, 8'h22, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b1, 32'h202, 8'h33, 1'b0, 32'h0);
        step();
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b0, 32'h0);
        @(negedge HCLK);
        check("q3_level", 32'(fifo_level), 32'd3);
        step();
        nwrites = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0);
            @(negedge HCLK);
            if (CPU_HREADY) begin
                done = 1'b1;
            end else begin
                if (M_HTRANS == 2'b10 && M_HWRITE) nwrites++;
                step();
            end
        end
        check("q3_replay_reached", 32'(done), 32'h1);
        check("q3_writes_before_replay", 32'(nwrites), 32'd3);
        check("q3_replay_grant", 32'(grant_loader), 32'h0);
        check("q3_replay_haddr", M_HADDR, 32'h1FC0_0014);
        step();

        // Asynchronous reset in the middle of a load
        CPU_HADDR = 32'h1FC0_0018;
        drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0);
        step();
        drive(1'b1, 1'b1, 32'h300, 8'h44, 1'b0, 32'h0);
        step();
        drive(1'b1, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0);
        check("prerst_grant", 32'(grant_loader), 32'h1);
        check("prerst_level", 32'(fifo_level), 32'd1);
        #2;
        HRESETn = 1'b0;
        #1;
        check("midrst_grant", 32'(grant_loader), 32'h0);
        check("midrst_level", 32'(fifo_level), 32'h0);
        check("midrst_htrans", 32'(M_HTRANS), 32'(CPU_HTRANS));
        check("midrst_ovf", 32'(loader_overflow), 32'h0);
        check("midrst_hready", 32'(CPU_HREADY), 32'(S_HREADY));
        step();
        drive(1'b0, 1'b0, 32'h0, 8'h00, 1'b1, 32'h0);
        HRESETn = 1'b1;

        // Random traffic against a transaction-level model
        start_addr   = 32'h2000_0000;
        cpu_addr     = start_addr;
        fab_cpu_next = start_addr;
        cpu_prev     = 32'h0;
        cpu_has_prev = 1'b0;
        dp_active    = 1'b0;
        dp_write     = 1'b0;
        dp_addr      = 32'h0;
        dp_byte      = 8'h00;
        exp_ovf      = 1'b0;
        ip           = 1'b0;
        for (int c = 0; c < 2060; c++) begin
            if (c >= 2000) ip = 1'b0;
            else if ($urandom_range(0, 29) == 0) ip = ~ip;
            in_progress   = ip;
            write_enable  = ip && ($urandom_range(0, 2) == 0);
            write_address = $urandom;
            write_byte    = 8'($urandom);
            S_HREADY      = dp_active ? ($urandom_range(0, 3) != 0) : 1'b1;
            S_HRDATA      = (dp_active && !dp_write) ? rd_pattern(dp_addr) : 32'h0;
            CPU_HADDR     = cpu_addr;
            @(negedge HCLK);
            check("rnd_level", 32'(fifo_level), 32'(q.size()));
            check("rnd_ovf", 32'(loader_overflow), 32'(exp_ovf));
            check("rnd_exclusive", 32'(CPU_HREADY & grant_loader), 32'h0);
            if (CPU_HREADY) begin
                if (cpu_has_prev) check("rnd_cpu_rdata", CPU_HRDATA, rd_pattern(cpu_prev));
                check("rnd_cpu_hresp", 32'(CPU_HRESP), 32'h0);
                cpu_prev     = cpu_addr;
                cpu_has_prev = 1'b1;
                cpu_addr     = cpu_addr + 32'd4;
            end
            if (S_HREADY) begin
                if (dp_active && dp_write) check("rnd_wdata", M_HWDATA, {4{dp_byte}});
                dp_active = (M_HTRANS == 2'b10);
                if (dp_active) begin
                    dp_write = M_HWRITE;
                    dp_addr  = M_HADDR;
                    if (M_HWRITE) begin
                        check("rnd_ldr_queued", 32'(q.size() != 0), 32'h1);
                        check("rnd_ldr_attr", 32'({M_HSIZE, M_HBURST, M_HPROT, M_HMASTLOCK, grant_loader}),
                              32'({3'b000, 3'b000, 4'b0011, 1'b0, 1'b1}));
                        if (q.size() != 0) begin
                            check("rnd_ldr_addr", M_HADDR, q[0][39:8]);
                            dp_byte = q[0][7:0];
                            void'(q.pop_front());
                        end
                    end else begin
                        check("rnd_cpu_addr", M_HADDR, fab_cpu_next);
                        fab_cpu_next = fab_cpu_next + 32'd4;
                    end
                end
            end
            if (write_enable) begin
                if (q.size() < DEPTH) q.push_back({write_address, write_byte});
                else exp_ovf = 1'b1;
            end
            step();
        end
        check("rnd_drained", 32'(q.size()), 32'h0);
        check("rnd_level_final", 32'(fifo_level), 32'h0);
        check("rnd_cpu_progress", 32'(cpu_addr > start_addr + 32'd400), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
